// File: rtl/fu_pkg.sv
// Function unit encodings, multiplier state enum and datapath width.
// Shared by the function unit and the shift-add multiplier controller.
package fu_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] FS_PASS_A  = 4'b0000;
    localparam logic [3:0] FS_INC     = 4'b0001;
    localparam logic [3:0] FS_ADD     = 4'b0010;
    localparam logic [3:0] FS_ADD_INC = 4'b0011;
    localparam logic [3:0] FS_SUB_DEC = 4'b0100;
    localparam logic [3:0] FS_SUB     = 4'b0101;
    localparam logic [3:0] FS_DEC     = 4'b0110;
    localparam logic [3:0] FS_AND     = 4'b1000;
    localparam logic [3:0] FS_OR      = 4'b1001;
    localparam logic [3:0] FS_XOR     = 4'b1010;
    localparam logic [3:0] FS_NOT_A   = 4'b1011;
    localparam logic [3:0] FS_PASS_B  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/Busy/Done handshake between the control unit and the multiplier.
// master = control unit, slave = multiplier.
interface shift_add_multiplier_if;
    import fu_pkg::*;

    logic               Start;
    logic [WIDTH-1:0]   Multiplicand;
    logic [WIDTH-1:0]   Multiplier;
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Product;

    modport master (
        output Start, Multiplicand, Multiplier,
        input  Busy, Done, Product
    );

    modport slave (
        input  Start, Multiplicand, Multiplier,
        output Busy, Done, Product
    );

endinterface

// File: rtl/shift_add_multiplier.sv
// 16x16 unsigned shift-add multiplier driving the shared function unit.
// Optional: `define SHIFT_ADD_SKIP_ZERO_EN skips ADD for zero multiplier bits.
module shift_add_multiplier
    import fu_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Reset_n,
    shift_add_multiplier_if.slave  bus,
    output logic [WIDTH-1:0]       FuA,
    output logic [WIDTH-1:0]       FuB,
    output logic [3:0]             FuSelect,
    input  logic [WIDTH-1:0]       FuResult,
    input  logic                   FuCarryOut
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             c_q, c_d;
    logic [3:0]       count_q, count_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        c_d      = c_q;
        count_d  = count_q;
        FuSelect = FS_PASS_A;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    mcand_d = bus.Multiplicand;
                    lo_d    = bus.Multiplier;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    count_d = '0;
`ifdef SHIFT_ADD_SKIP_ZERO_EN
                    state_d = bus.Multiplier[0] ? ST_ADD
                                                : ST_SHIFT;
`else
                    state_d = ST_ADD;
`endif
                end
            end
            ST_ADD: begin
                // Pass A leaves Hi intact with a zero carry.
                FuSelect = lo_q[0] ? FS_ADD : FS_PASS_A;
                c_d      = FuCarryOut;
                hi_d     = FuResult;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                {c_d, hi_d, lo_d} = {1'b0, c_q, hi_q,
                                     lo_q[WIDTH-1:1]};
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    state_d = ST_DONE;
                end else begin
`ifdef SHIFT_ADD_SKIP_ZERO_EN
                    // lo_q[1] becomes Lo[0] after this shift.
                    state_d = lo_q[1] ? ST_ADD : ST_SHIFT;
`else
                    state_d = ST_ADD;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign FuA         = hi_q;
    assign FuB         = mcand_q;
    assign bus.Busy    = (state_q != ST_IDLE);
    assign bus.Done    = (state_q == ST_DONE);
    assign bus.Product = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench: multiplier plus a behavioural function unit, checked
// against a plain arithmetic product/latency model.
module tb_shift_add_multiplier;
    import fu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [15:0] FuA, FuB, FuResult;
    logic [3:0]  FuSelect;
    logic        FuCarryOut;
    logic [16:0] fu_r;

    int tests = 0;
    int fails = 0;

    shift_add_multiplier_if bus();

    shift_add_multiplier dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .bus        (bus),
        .FuA        (FuA),
        .FuB        (FuB),
        .FuSelect   (FuSelect),
        .FuResult   (FuResult),
        .FuCarryOut (FuCarryOut)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        fu_r = {1'b0, FuA};
        case (FuSelect)
            FS_INC:     fu_r = {1'b0, FuA} + 17'd1;
            FS_ADD:     fu_r = {1'b0, FuA} + {1'b0, FuB};
            FS_ADD_INC: fu_r = {1'b0, FuA} + {1'b0, FuB} + 17'd1;
            FS_SUB_DEC: fu_r = {1'b0, FuA} + {1'b0, ~FuB};
            FS_SUB:     fu_r = {1'b0, FuA} + {1'b0, ~FuB} + 17'd1;
            FS_DEC:     fu_r = {1'b0, FuA} + 17'h0FFFF;
            FS_AND:     fu_r = {1'b0, FuA & FuB};
            FS_OR:      fu_r = {1'b0, FuA | FuB};
            FS_XOR:     fu_r = {1'b0, FuA ^ FuB};
            FS_NOT_A:   fu_r = {1'b0, ~FuA};
            FS_PASS_B:  fu_r = {1'b0, FuB};
            default:    fu_r = {1'b0, FuA};
        endcase
    end
    assign FuResult   = fu_r[15:0];
    assign FuCarryOut = fu_r[16];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input logic [15:0] b);
`ifdef SHIFT_ADD_SKIP_ZERO_EN
        return 17 + $countones(b);
`else
        return 33;
`endif
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.Busy, 1'b0);
        chk({tag, "_done"}, bus.Done, 1'b0);
        chk({tag, "_prod"}, bus.Product, 32'h0);
        chk({tag, "_fsel"}, FuSelect, 4'h0);
        chk({tag, "_fua"}, FuA, 16'h0);
        chk({tag, "_fub"}, FuB, 16'h0);
    endtask

    task automatic run_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input bit repulse);
        int el, dc, busy_err, fs_err, adds;
        logic [31:0] exp_p, p_done;
        el = lat(b);
        exp_p = 32'(a) * 32'(b);
        dc = -1; busy_err = 0; fs_err = 0; adds = 0;
        p_done = 32'h0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier = b;
        for (int cyc = 1; cyc <= el + 1; cyc++) begin
            @(negedge Clock);
            if (bus.Busy !== (cyc <= el)) busy_err++;
            if (FuSelect == FS_ADD) adds++;
            else if (FuSelect != FS_PASS_A) fs_err++;
            if (bus.Done === 1'b1 && dc < 0) begin
                dc = cyc;
                p_done = bus.Product;
            end
            bus.Start = repulse && (cyc == 5 || cyc == el);
            if (bus.Start) begin
                bus.Multiplicand = 16'hABCD;
                bus.Multiplier = 16'h1357;
            end
        end
        bus.Start = 1'b0;
        chk("done_cycle", dc, el);
        chk("busy_profile_errs", busy_err, 0);
        chk("fsel_bad_codes", fs_err, 0);
        chk("fsel_add_count", adds, $countones(b));
        chk("product_at_done", p_done, exp_p);
        chk("product_held", bus.Product, exp_p);
    endtask

    task automatic run_held(input logic [15:0] a1, b1,
                            input logic [15:0] a2, b2);
        int l1, l2, d1, d2;
        logic [31:0] p1, p2;
        l1 = lat(b1);
        l2 = lat(b2);
        d1 = -1; d2 = -1;
        p1 = 32'h0; p2 = 32'h0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Multiplicand = a1;
        bus.Multiplier = b1;
        for (int cyc = 1; cyc <= l1 + l2 + 4; cyc++) begin
            @(negedge Clock);
            if (bus.Done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    p1 = bus.Product;
                    bus.Multiplicand = a2;
                    bus.Multiplier = b2;
                end else if (d2 < 0) begin
                    d2 = cyc;
                    p2 = bus.Product;
                    bus.Start = 1'b0;
                end
            end
        end
        bus.Start = 1'b0;
        chk("held_done1", d1, l1);
        chk("held_done2", d2, l1 + 1 + l2);
        chk("held_prod1", p1, 32'(a1) * 32'(b1));
        chk("held_prod2", p2, 32'(a2) * 32'(b2));
    endtask

    task automatic run_abort;
        int done_err;
        done_err = 0;
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Multiplicand = 16'd7;
        bus.Multiplier = 16'd9;
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(negedge Clock);
            bus.Start = 1'b0;
        end
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clock);
            if (bus.Done !== 1'b0) done_err++;
            if (cyc == 3) Reset_n = 1'b1;
        end
        chk("abort_no_done", done_err, 0);
        run_op(16'd7, 16'd9, 1'b0);
        chk("abort_rerun", bus.Product, 32'h3F);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        bus.Start = 1'b0;
        bus.Multiplicand = 16'h0;
        bus.Multiplier = 16'h0;
        #12;
        chk_reset_vals("reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        chk_reset_vals("idle");

        run_op(16'd3, 16'd5, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);
        run_op(16'h8000, 16'h0002, 1'b0);
        run_op(16'h0000, 16'h1234, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0);
        run_op(16'h0123, 16'h0456, 1'b1);
        run_held(16'h00FF, 16'h0101, 16'hBEEF, 16'h8001);
        run_abort();
        for (int i = 0; i < 16; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
